lfsr_prng: RTL



---
 rtl/lfsr_prng.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lfsr_prng.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_prng
//  Description : Parametrised Fibonacci LFSR pseudo-random generator with a
//                seed handshake, warm-up discard, multi-step unrolled advance,
//                zero-seed guard and a valid/ready output stream.
//                Optional build macro: LFSR_PRNG_FREERUN_EN (when defined the
//                LFSR advances every cycle in WARMUP and RUN, independent of
//                consumption).
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_prng #(
    parameter int          WIDTH        = 32,
    parameter int          STEPS        = 1,
    parameter int          OUT_WIDTH    = 32,
    parameter int          WARMUP       = 0,
    parameter logic [63:0] DEFAULT_SEED = 64'd1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     seed,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    output logic [OUT_WIDTH-1:0] rand_out,
    output logic                 rand_valid,
    input  logic                 rand_ready
);

    // Elaboration-time parameter legality checks
    if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("lfsr_prng: WIDTH must be 4, 8, 16, 32 or 64");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_prng: STEPS must be in 1..WIDTH");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_bad_out_width
        $error("lfsr_prng: OUT_WIDTH must be in 1..WIDTH");
    end
    if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
        $error("lfsr_prng: WARMUP must be in 0..255");
    end
    if (DEFAULT_SEED[WIDTH-1:0] == '0) begin : g_bad_default_seed
        $error("lfsr_prng: DEFAULT_SEED must be nonzero in the low WIDTH bits");
    end

    // Feedback tap masks; the XOR of the masked bits becomes the new bit 0
    localparam logic [63:0] c_TAPS64 =
        (WIDTH == 4)  ? 64'h0000_0000_0000_000C :
        (WIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
        (WIDTH == 16) ? 64'h0000_0000_0000_D008 :
        (WIDTH == 32) ? 64'h0000_0000_8020_0003 :
                        64'hD800_0000_0000_0000;
    localparam logic [WIDTH-1:0] c_TAPS      = c_TAPS64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_DEF_SEED  = DEFAULT_SEED[WIDTH-1:0];
    localparam logic [7:0]       c_WARMUP    = WARMUP[7:0];

    typedef enum logic [1:0] {
        S_UNSEEDED = 2'd0,
        S_WARMUP   = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t                 r_fsm;
    state_t                 w_fsm_next;
    logic [WIDTH-1:0]       r_state;
    logic [WIDTH-1:0]       w_state_next;
    logic [7:0]             r_count;
    logic [7:0]             w_count_next;
    logic [OUT_WIDTH-1:0]   r_rand_out;
    logic [OUT_WIDTH-1:0]   w_rand_out_next;

    logic [WIDTH-1:0]       w_lfsr_adv;
    logic [WIDTH-1:0]       w_seed_val;
    logic                   w_seed_acc;
    logic                   w_rand_hs;
    logic                   w_adv_en;
    logic [OUT_WIDTH-1:0]   w_hs_word;

    // STEPS single shifts unrolled into one combinational advance
    function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int i = 0; i < STEPS; i++) begin
            v = {v[WIDTH-2:0], ^(v & c_TAPS)};
        end
        return v;
    endfunction

    assign w_lfsr_adv = lfsr_advance(r_state);
    assign w_seed_val = (seed == '0) ? c_DEF_SEED : seed;

    // Handshake flags come straight from registered state
    assign seed_ready = (r_fsm != S_WARMUP);
    assign rand_valid = (r_fsm == S_RUN);
    assign rand_out   = r_rand_out;
    assign w_seed_acc = seed_valid & seed_ready;
    assign w_rand_hs  = rand_valid & rand_ready;

`ifdef LFSR_PRNG_FREERUN_EN
    // Free-running: advance every active cycle; a handshake captures the
    // state present at the edge so words stay fresh without extra logic depth
    assign w_adv_en  = (r_fsm == S_WARMUP) || (r_fsm == S_RUN);
    assign w_hs_word = r_state[OUT_WIDTH-1:0];
`else
    // Consumption-gated: advance only while discarding warm-up words and on
    // handshakes, so every sequence value is delivered exactly once
    assign w_adv_en  = ((r_fsm == S_WARMUP) && (r_count != 8'd0)) ||
                       ((r_fsm == S_RUN) && w_rand_hs);
    assign w_hs_word = w_lfsr_adv[OUT_WIDTH-1:0];
`endif

    // Next-state and datapath selection; a seed accept overrides everything
    always_comb begin
        w_fsm_next      = r_fsm;
        w_state_next    = w_adv_en ? w_lfsr_adv : r_state;
        w_count_next    = r_count;
        w_rand_out_next = r_rand_out;
        unique case (r_fsm)
            S_WARMUP: begin
                if (r_count == 8'd0) begin
                    w_fsm_next      = S_RUN;
                    w_rand_out_next = r_state[OUT_WIDTH-1:0];
                end else begin
                    w_count_next    = r_count - 8'd1;
                end
            end
            S_RUN: begin
                if (w_rand_hs) begin
                    w_rand_out_next = w_hs_word;
                end
            end
            default: begin
            end
        endcase
        if (w_seed_acc) begin
            w_state_next = w_seed_val;
            w_count_next = c_WARMUP;
            w_fsm_next   = S_WARMUP;
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm      <= S_UNSEEDED;
            r_state    <= c_DEF_SEED;
            r_count    <= 8'd0;
            r_rand_out <= '0;
        end else begin
            r_fsm      <= w_fsm_next;
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_rand_out <= w_rand_out_next;
        end
    end

endmodule
`default_nettype wire
